key_event_classifier: RTL
=========================

// Module: key_event_classifier
// PURPOSE
//  Consumes the debounced, synchronised key level from the debounce stage.
//  Classifies each key gesture and emits one single-cycle event pulse per gesture:
//  short press, double click, long press, and auto-repeat while a long press is held.
//  Sits between the debounce stage and the application control FSMs, e.g. mode select.
// PARAMETERS
//  CYC_PER_MS   50000  clk cycles per millisecond (50 MHz); >=2
//  LONG_MS      1000   hold time (ms) to qualify a long press; >=1
//  DBL_MS       300    max release gap (ms) before a second press counts as double click; >=1
//  REPEAT_MS    200    repeat period (ms) while held after long press; >=1
//  ACTIVE_LOW   1      1: key_level==0 means pressed (idle-high key); 0: active-high
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  reset, asynchronous, active-low
//  key_level    in   1  debounced key level, already synchronous to clk
//  short_press  out  1  1-cycle pulse: single short press, confirmed after DBL_MS
//  double_click out  1  1-cycle pulse: second press released
//  long_press   out  1  1-cycle pulse: key held LONG_MS
//  repeat_evt   out  1  1-cycle pulse every REPEAT_MS while still held after long_press
//  busy         out  1  high in every state except IDLE
// BEHAVIOUR
//  Definitions
//  - pressed = key_level ^ ACTIVE_LOW.
//  - All outputs are registered; reset value 0. The state resets to IDLE.
//  - Asserting rst_n mid-gesture aborts the gesture; no pulse is emitted.
//  - At most one event output is high in any cycle.
//  Timebase
//  - pre_cnt: width $clog2(CYC_PER_MS); 0..CYC_PER_MS-1.
//  - tick = (pre_cnt == CYC_PER_MS-1).
//  - ms_cnt: width $clog2(max(LONG_MS,DBL_MS,REPEAT_MS)+1); increments on tick.
//  - pre_cnt and ms_cnt both clear on every state transition; ms_cnt saturates, never wraps.
//  - A threshold X is "reached" in the cycle where tick && ms_cnt == X-1.
//  - That cycle is exactly X*CYC_PER_MS cycles after state entry (entry cycle = cycle 1).
//  FSM: IDLE, PRESS1, WAIT2, PRESS2, HOLD
//  - IDLE:   pressed -> PRESS1.
//  - PRESS1: !pressed -> WAIT2.
//            LONG_MS reached -> HOLD, long_press=1.
//            If !pressed and LONG_MS are reached in the same cycle, the release wins:
//            go to WAIT2, no long_press.
//  - WAIT2:  pressed -> PRESS2.
//            DBL_MS reached -> IDLE, short_press=1.
//            If pressed and DBL_MS are reached in the same cycle, the press wins:
//            go to PRESS2, no short_press.
//  - PRESS2: !pressed -> IDLE, double_click=1.
//            No long-press detection in PRESS2; it waits indefinitely.
//  - HOLD:   REPEAT_MS reached && pressed -> repeat_evt=1, restart the timebase, stay in HOLD.
//            !pressed -> IDLE, no pulse; release beats a coincident repeat.
//  Latency
//  - Pulses appear one cycle after the deciding condition is sampled (registered outputs).
//  - long_press rises LONG_MS*CYC_PER_MS+1 cycles after the first cycle pressed is sampled in IDLE.
//  - A press that goes straight back to IDLE emits exactly one pulse.
//  - A press that goes through HOLD emits one long_press, then 0..N repeat_evt.
// STRUCTURE
//  Shared package key_pkg
//  - typedef enum logic [2:0] key_state_t {IDLE,PRESS1,WAIT2,PRESS2,HOLD}.
//  - function clog2_min1() for counter widths.
//  Sub-module ms_timebase
//  - Contains pre_cnt, ms_cnt, tick and the saturation logic.
//  - Ports clk, rst_n, clr, ms_cnt, tick.
//  - Parameters CYC_PER_MS, MS_W.
//  Top level
//  - FSM and registered pulse outputs only.
// TESTING  (CYC_PER_MS=10, LONG_MS=5, DBL_MS=3, REPEAT_MS=2, ACTIVE_LOW=1)
//  T1 short press
//     press 20 cycles, release.
//     -> short_press single pulse 31 cycles after release sampled.
//     -> no other pulses.
//  T2 double click
//     press 20, release 15, press 20, release.
//     -> double_click pulse 1 cycle after second release.
//     -> no short_press.
//  T3 long press + repeat
//     hold 95 cycles.
//     -> long_press at cycle 51.
//     -> repeat_evt at cycles 71 and 91.
//     -> after release, busy falls 1 cycle later with no extra pulse.
//  T4 boundary
//     release exactly in the cycle LONG_MS is reached.
//     -> WAIT2 path, short_press later.
//     press exactly in the cycle DBL_MS is reached.
//     -> PRESS2 path, double_click only.
//  T5 reset mid-gesture
//     assert rst_n low during PRESS1 and during HOLD.
//     -> all outputs 0 immediately.
//     -> busy 0; no pulse after release.
//  T6 ACTIVE_LOW=0 rerun of T1-T3 with inverted stimulus -> identical pulse timing.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and width helpers for the key event classifier.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } key_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_timebase.sv
// Millisecond timebase: cycle prescaler plus saturating millisecond counter.
module ms_timebase #(
    parameter int CYC_PER_MS = 50000,
    parameter int MS_W       = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic [MS_W-1:0] ms_cnt,
    output logic            tick
);
    import key_pkg::*;

    localparam int PRE_W = clog2_min1(CYC_PER_MS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_MS - 1);
    localparam logic [MS_W-1:0]  MS_SAT   = '1;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;

    assign tick   = (pre_cnt_q == PRE_LAST);
    assign ms_cnt = ms_cnt_q;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        ms_cnt_d  = ms_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
            ms_cnt_d  = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            // Saturate so a long wait can never alias back onto a threshold.
            if (ms_cnt_q != MS_SAT)
                ms_cnt_d = ms_cnt_q + 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            ms_cnt_q  <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ms_cnt_q  <= ms_cnt_d;
        end
    end

endmodule

// File: rtl/key_event_classifier.sv
// Turns a debounced key level into short / double / long / repeat event pulses.
module key_event_classifier #(
    parameter int CYC_PER_MS = 50000,
    parameter int LONG_MS    = 1000,
    parameter int DBL_MS     = 300,
    parameter int REPEAT_MS  = 200,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_evt,
    output logic busy
);
    import key_pkg::*;

    localparam int MAX_MS = max3(LONG_MS, DBL_MS, REPEAT_MS);
    localparam int MS_W   = clog2_min1(MAX_MS + 1);
    localparam logic ACT_LVL = (ACTIVE_LOW != 0);

    localparam logic [MS_W-1:0] LONG_M1 = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] DBL_M1  = MS_W'(DBL_MS - 1);
    localparam logic [MS_W-1:0] REP_M1  = MS_W'(REPEAT_MS - 1);

    key_state_t      state_q, state_d;
    logic            short_q, short_d;
    logic            dbl_q, dbl_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            busy_q, busy_d;
    logic            restart;
    logic            clr;
    logic            tick;
    logic [MS_W-1:0] ms_cnt;
    logic            pressed;

    assign pressed = key_level ^ ACT_LVL;

    ms_timebase #(
        .CYC_PER_MS (CYC_PER_MS),
        .MS_W       (MS_W)
    ) u_timebase (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .ms_cnt (ms_cnt),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        restart = 1'b0;
        // Key transitions are tested first so they win over coincident timeouts.
        unique case (state_q)
            IDLE:   if (pressed) state_d = PRESS1;
            PRESS1: begin
                if (!pressed) state_d = WAIT2;
                else if (tick && ms_cnt == LONG_M1) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (pressed) state_d = PRESS2;
                else if (tick && ms_cnt == DBL_M1) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (!pressed) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            HOLD: begin
                if (!pressed) state_d = IDLE;
                else if (tick && ms_cnt == REP_M1) begin
                    rep_d   = 1'b1;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign clr = (state_d != state_q) || restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign repeat_evt   = rep_q;
    assign busy         = busy_q;

endmodule
